// File: rtl/jtag_bridge_pkg.sv
// jtag_bridge shared definitions: IR opcodes,
// bus FSM states and STATUS register bit positions.
package jtag_bridge_pkg;

  localparam int IR_CTRL   = 0;
  localparam int IR_ADDR   = 1;
  localparam int IR_WDATA  = 2;
  localparam int IR_RDATA  = 3;
  localparam int IR_STATUS = 4;

  localparam int ST_CPU_RST = 0;
  localparam int ST_BUSY    = 1;
  localparam int ST_OVR     = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ
  } state_t;

endpackage

// File: rtl/jtag_bridge_if.sv
// Bus request channel between bridge (master) and
// memory/arbiter (slave): req/we/addr/wdata out, rdata/ack in.
interface jtag_bridge_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack
  );

endinterface

// File: rtl/jtag_bridge_sampler.sv
// jtag_sampler: SYNC_STAGES synchroniser for the async TAP lines
// plus tck rising-edge detect (o_tev, one clk wide).
module jtag_sampler #(
  parameter int IR_W        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_tck,
  input  logic            i_tdi,
  input  logic [IR_W-1:0] i_ir,
  input  logic            i_cdr,
  input  logic            i_sdr,
  input  logic            i_udr,
  input  logic            i_uir,
  output logic            o_tev,
  output logic            o_tdi,
  output logic [IR_W-1:0] o_ir,
  output logic            o_cdr,
  output logic            o_sdr,
  output logic            o_udr,
  output logic            o_uir
);

  localparam int W = IR_W + 6;

  logic [W-1:0] r_sync [SYNC_STAGES];
  logic         r_tck_d;
  logic [W-1:0] w_in;
  logic [W-1:0] w_out;

  assign w_in  = {i_ir, i_uir, i_udr, i_sdr,
                  i_cdr, i_tdi, i_tck};
  assign w_out = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        r_sync[i] <= '0;
      r_tck_d <= 1'b0;
    end else begin
      r_sync[0] <= w_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        r_sync[i] <= r_sync[i-1];
      r_tck_d <= w_out[0];
    end
  end

  assign o_tev = w_out[0] & ~r_tck_d;
  assign {o_ir, o_uir, o_udr, o_sdr,
          o_cdr, o_tdi} = w_out[W-1:1];

endmodule

// File: rtl/jtag_bridge.sv
// jtag_bridge: virtual-JTAG to bus debug bridge (DR/IR, CTRL/STATUS,
// bus FSM). Ports: TAP in, tdo out, bus master if, cpu_reset out.
module jtag_bridge
  import jtag_bridge_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int ADDR_INC    = 2,
  parameter int IR_W        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            tck,
  input  logic            tdi,
  output logic            tdo,
  input  logic [IR_W-1:0] ir_in,
  input  logic            vs_cdr,
  input  logic            vs_sdr,
  input  logic            vs_udr,
  input  logic            vs_uir,
  output logic            cpu_reset,
  jtag_bridge_if.master   bus
);

  logic              w_tev, s_tdi;
  logic [IR_W-1:0]   s_ir;
  logic              s_cdr, s_sdr, s_udr, s_uir;

  jtag_sampler #(
    .IR_W        (IR_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_smp (
    .clk     (clk),
    .reset_n (reset_n),
    .i_tck   (tck),
    .i_tdi   (tdi),
    .i_ir    (ir_in),
    .i_cdr   (vs_cdr),
    .i_sdr   (vs_sdr),
    .i_udr   (vs_udr),
    .i_uir   (vs_uir),
    .o_tev   (w_tev),
    .o_tdi   (s_tdi),
    .o_ir    (s_ir),
    .o_cdr   (s_cdr),
    .o_sdr   (s_sdr),
    .o_udr   (s_udr),
    .o_uir   (s_uir)
  );

  state_t            r_state, w_state_nxt;
  logic [IR_W-1:0]   r_ir;
  logic [DATA_W-1:0] r_dr, w_dr_nxt, r_rbuf, w_status;
  logic [ADDR_W-1:0] r_addr, r_baddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_tdo, r_cpu_rst, r_ovr;
  logic              r_req, r_we, r_pend, r_pend_we;

  logic w_cdr, w_sdr, w_udr, w_uir;
  logic w_ir_ctrl, w_ir_addr, w_ir_wr;
  logic w_ir_rd, w_ir_st;
  logic w_lwr, w_lrd, w_launch;
  logic w_go, w_go_we, w_done, w_ovr, w_pend_set;

  assign w_cdr = w_tev & s_cdr;
  assign w_sdr = w_tev & s_sdr;
  assign w_udr = w_tev & s_udr;
  assign w_uir = w_tev & s_uir;

  assign w_ir_ctrl = r_ir == IR_W'(IR_CTRL);
  assign w_ir_addr = r_ir == IR_W'(IR_ADDR);
  assign w_ir_wr   = r_ir == IR_W'(IR_WDATA);
  assign w_ir_rd   = r_ir == IR_W'(IR_RDATA);
  assign w_ir_st   = r_ir == IR_W'(IR_STATUS);

  // IR update to RDATA only prefetches when idle;
  // when busy it is silently skipped, not an overrun.
  assign w_lwr    = w_udr & w_ir_wr;
  assign w_lrd    = (w_udr & w_ir_rd) |
                    (w_uir & (s_ir == IR_W'(IR_RDATA)) &
                     (r_state == S_IDLE));
  assign w_launch = w_lwr | w_lrd;

  always_comb begin
    w_status             = '0;
    w_status[ST_CPU_RST] = r_cpu_rst;
    w_status[ST_BUSY]    = r_state != S_IDLE;
    w_status[ST_OVR]     = r_ovr;
  end

  always_comb begin
    w_dr_nxt = r_dr;
    if (w_cdr) begin
      unique case (1'b1)
        w_ir_rd: w_dr_nxt = r_rbuf;
        w_ir_st: w_dr_nxt = w_status;
        default: ;
      endcase
    end else if (w_sdr) begin
      w_dr_nxt = {s_tdi, r_dr[DATA_W-1:1]};
    end
  end

  // A launch landing on the ack cycle is parked in r_pend
  // and issued from IDLE on the following clk.
  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_go_we     = 1'b0;
    w_done      = 1'b0;
    w_ovr       = 1'b0;
    w_pend_set  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_pend) begin
          w_go    = 1'b1;
          w_go_we = r_pend_we;
        end else if (w_launch) begin
          w_go    = 1'b1;
          w_go_we = w_lwr;
        end
      end
      default: begin
        if (bus.ack) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
          w_pend_set  = w_launch;
        end else if (w_launch) begin
          w_ovr = 1'b1;
        end
      end
    endcase
    if (w_go)
      w_state_nxt = w_go_we ? S_WRITE : S_READ;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ir      <= '0;
      r_dr      <= '0;
      r_tdo     <= 1'b0;
      r_addr    <= '0;
      r_rbuf    <= '0;
      r_cpu_rst <= 1'b0;
      r_ovr     <= 1'b0;
      r_pend    <= 1'b0;
      r_pend_we <= 1'b0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_baddr   <= '0;
      r_wdata   <= '0;
    end else begin
      r_dr   <= w_dr_nxt;
      r_tdo  <= w_dr_nxt[0];
      r_pend <= w_pend_set;
      if (w_pend_set) r_pend_we <= w_lwr;
      if (w_uir) r_ir <= s_ir;
      if (w_ovr) r_ovr <= 1'b1;
      if (w_done) begin
        r_req  <= 1'b0;
        r_addr <= r_addr + ADDR_W'(ADDR_INC);
        if (r_state == S_READ) r_rbuf <= bus.rdata;
      end
      if (w_udr & w_ir_ctrl) begin
        r_cpu_rst <= r_dr[0];
        if (r_dr[1]) r_ovr <= 1'b0;
      end
      if (w_udr & w_ir_addr)
        r_addr <= r_dr[ADDR_W-1:0];
      if (w_go) begin
        r_req   <= 1'b1;
        r_we    <= w_go_we;
        r_baddr <= r_addr;
        if (w_go_we) r_wdata <= r_dr;
      end
    end
  end

  assign tdo       = r_tdo;
  assign cpu_reset = r_cpu_rst;
  assign bus.req   = r_req;
  assign bus.we    = r_we;
  assign bus.addr  = r_baddr;
  assign bus.wdata = r_wdata;

endmodule

// File: tb/tb_jtag_bridge.sv
// tb_jtag_bridge: directed JTAG scans against a small bus memory,
// run at f_clk/f_tck = 4 and 13 with random tck stretch.
module tb_jtag_bridge;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tck, tdi, tdo;
  logic [3:0] ir_in;
  logic       vs_cdr, vs_sdr, vs_udr, vs_uir;
  logic       cpu_reset;

  int n_chk  = 0;
  int n_fail = 0;
  int g_ratio = 4;
  logic g_tdo;

  jtag_bridge_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  jtag_bridge dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tck       (tck),
    .tdi       (tdi),
    .tdo       (tdo),
    .ir_in     (ir_in),
    .vs_cdr    (vs_cdr),
    .vs_sdr    (vs_sdr),
    .vs_udr    (vs_udr),
    .vs_uir    (vs_uir),
    .cpu_reset (cpu_reset),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] lg_addr [$];
  logic [31:0] lg_data [$];
  logic        hold;
  int          cnt;
  int          nreq;
  logic        req_q;

  always @(negedge clk) begin
    if (!reset_n) begin
      bus.ack   = 1'b0;
      bus.rdata = 32'h0;
      cnt       = 0;
      req_q     = 1'b0;
    end else begin
      if (bus.req && !req_q) nreq++;
      req_q = bus.req;
      if (bus.ack) begin
        bus.ack = 1'b0;
      end else if (bus.req && !hold) begin
        if (cnt >= 1) begin
          bus.ack = 1'b1;
          cnt     = 0;
          if (bus.we) mem[bus.addr] = bus.wdata;
          else bus.rdata = mem.exists(bus.addr) ?
                           mem[bus.addr] : 32'h0;
          lg_addr.push_back(bus.addr);
          lg_data.push_back(bus.we ? bus.wdata : bus.rdata);
        end else begin
          cnt++;
        end
      end
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lo_t();
    return g_ratio / 2 + int'($urandom_range(0, 1));
  endfunction

  function automatic int hi_t();
    return g_ratio - g_ratio / 2 + int'($urandom_range(0, 1));
  endfunction

  task automatic tck_cyc(input logic c, input logic s,
                         input logic u, input logic i,
                         input logic d);
    vs_cdr = c; vs_sdr = s; vs_udr = u;
    vs_uir = i; tdi = d;
    repeat (lo_t()) @(negedge clk);
    g_tdo = tdo;
    tck = 1'b1;
    repeat (hi_t()) @(negedge clk);
    tck = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tck_cyc(0, 0, 0, 0, 0);
  endtask

  task automatic ir_scan(input logic [3:0] code);
    ir_in = code;
    tck_cyc(0, 0, 0, 1, 0);
    idle(3);
  endtask

  task automatic dr_scan(input  logic [31:0] din,
                         output logic [31:0] dout);
    tck_cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 32; k++) begin
      tck_cyc(0, 1, 0, 0, din[k]);
      dout[k] = g_tdo;
    end
    tck_cyc(0, 0, 1, 0, 0);
    idle(3);
  endtask

  task automatic wait_req(input logic lvl, input string tag);
    int n = 0;
    while (bus.req !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(bus.req), 64'(lvl));
  endtask

  task automatic chk_reset_vals(input string pfx);
    check({pfx, "_req"},   64'(bus.req),   64'h0);
    check({pfx, "_we"},    64'(bus.we),    64'h0);
    check({pfx, "_addr"},  64'(bus.addr),  64'h0);
    check({pfx, "_wdata"}, 64'(bus.wdata), 64'h0);
    check({pfx, "_tdo"},   64'(tdo),       64'h0);
    check({pfx, "_cpu"},   64'(cpu_reset), 64'h0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tck = 1'b0; tdi = 1'b0; ir_in = 4'h0;
    vs_cdr = 1'b0; vs_sdr = 1'b0;
    vs_udr = 1'b0; vs_uir = 1'b0;
    hold = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_pass();
    logic [31:0] d;
    int          b;
    int          nr;
    do_reset();

    b = lg_addr.size();
    ir_scan(4'd1); dr_scan(32'h0000_0100, d);
    ir_scan(4'd2);
    dr_scan(32'hDEAD_BEEF, d);
    dr_scan(32'h1234_5678, d);
    check("wr_cnt", 64'(lg_addr.size() - b), 64'd2);
    if (lg_addr.size() >= b + 2) begin
      check("wr0_addr", 64'(lg_addr[b]),   64'h100);
      check("wr0_data", 64'(lg_data[b]),   64'hDEAD_BEEF);
      check("wr1_addr", 64'(lg_addr[b+1]), 64'h102);
      check("wr1_data", 64'(lg_data[b+1]), 64'h1234_5678);
    end
    check("wr_addr_next", 64'(dut.r_addr), 64'h104);

    ir_scan(4'd1); dr_scan(32'h0000_0200, d);
    ir_scan(4'd2);
    dr_scan(32'hA5A5_A5A5, d);
    dr_scan(32'h5A5A_5A5A, d);
    ir_scan(4'd1); dr_scan(32'h0000_0200, d);
    ir_scan(4'd3);
    dr_scan(32'h0, d);
    check("rd0", 64'(d), 64'hA5A5_A5A5);
    dr_scan(32'h0, d);
    check("rd1", 64'(d), 64'h5A5A_5A5A);

    hold = 1'b1;
    nr = nreq;
    ir_scan(4'd2);
    dr_scan(32'h1111_1111, d);
    dr_scan(32'h2222_2222, d);
    check("ovr_nreq", 64'(nreq - nr), 64'd1);
    ir_scan(4'd4); dr_scan(32'h0, d);
    check("ovr_status", 64'(d), 64'h6);
    check("ovr_wdata", 64'(bus.wdata), 64'h1111_1111);
    check("ovr_baddr", 64'(bus.addr),  64'h206);
    ir_scan(4'd0); dr_scan(32'h2, d);
    ir_scan(4'd4); dr_scan(32'h0, d);
    check("ovr_clr_status", 64'(d), 64'h2);
    repeat (200) @(negedge clk);
    b = lg_addr.size();
    hold = 1'b0;
    wait_req(1'b0, "ovr_done");
    check("ovr_log_cnt", 64'(lg_addr.size() - b), 64'd1);
    if (lg_addr.size() > b) begin
      check("ovr_log_addr", 64'(lg_addr[b]), 64'h206);
      check("ovr_log_data", 64'(lg_data[b]), 64'h1111_1111);
    end
    idle(2);
    ir_scan(4'd4); dr_scan(32'h0, d);
    check("idle_status", 64'(d), 64'h0);

    ir_scan(4'd0); dr_scan(32'h1, d);
    check("cpu_set", 64'(cpu_reset), 64'h1);
    ir_scan(4'd4); dr_scan(32'h0, d);
    check("cpu_status", 64'(d), 64'h1);
    ir_scan(4'd0); dr_scan(32'h0, d);
    check("cpu_clr", 64'(cpu_reset), 64'h0);

    b = lg_addr.size();
    ir_scan(4'd1); dr_scan(32'hFFFF_FFFE, d);
    ir_scan(4'd2); dr_scan(32'hCAFE_F00D, d);
    if (lg_addr.size() > b)
      check("wrap_waddr", 64'(lg_addr[b]), 64'hFFFF_FFFE);
    else
      check("wrap_wcnt", 64'(lg_addr.size() - b), 64'd1);
    check("wrap_addr", 64'(dut.r_addr), 64'h0);
    hold = 1'b1;
    dr_scan(32'h0BAD_F00D, d);
    wait_req(1'b1, "mid_req_up");
    #2 reset_n = 1'b0;
    #1 check("mid_rst_req", 64'(bus.req), 64'h0);
    chk_reset_vals("mid_rst");
    hold = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    hold    = 1'b0;
    nreq    = 0;
    tck = 1'b0; tdi = 1'b0; ir_in = 4'h0;
    vs_cdr = 1'b0; vs_sdr = 1'b0;
    vs_udr = 1'b0; vs_uir = 1'b0;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      g_ratio = (p == 0) ? 4 : 13;
      run_pass();
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_bridge.md
# jtag_bridge

Parametrised JTAG-to-bus debug bridge: host-side loader and inspector for on-chip memory, generalising the write-only loader with read-back, status capture, configurable widths and a bus handshake. Virtual-JTAG TAP signals are oversampled in the system clock domain, so all state lives on `clk`. Sits between the vendor virtual-JTAG primitive and the memory/bus arbiter. Also drives the CPU hold-in-reset line.

## Interface
Parameters:
- `DATA_W`, 32: data register and bus data width (≥8).
- `ADDR_W`, 32: bus address width (≤ DATA_W).
- `ADDR_INC`, 2: post-transfer address increment.
- `IR_W`, 4: virtual IR width.
- `SYNC_STAGES`, 2: synchroniser depth on TAP inputs (≥2).

Ports:
- `clk` in 1: system clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `tck`, `tdi` in 1: raw TAP clock and data, treated as async data.
- `tdo` out 1: registered DR bit 0.
- `ir_in` in IR_W: virtual IR value.
- `vs_cdr`, `vs_sdr`, `vs_udr`, `vs_uir` in 1: virtual capture/shift/update-DR and update-IR states.
- `bus_req` out 1: transfer request.
- `bus_we` out 1: 1 = write.
- `bus_addr` out ADDR_W.
- `bus_wdata` out DATA_W.
- `bus_rdata` in DATA_W.
- `bus_ack` in 1: one-cycle completion.
- `cpu_reset` out 1: CPU hold-in-reset.

## Operation
- **TAP inputs:** all pass through SYNC_STAGES flops. A tck edge event (`tev`) fires for one clk when synchronised tck goes 0→1. All TAP actions happen only on `tev`, qualified by the synchronised state lines.
- **IR codes:** CTRL=0, ADDR=1, WDATA=2, RDATA=3, STATUS=4; others are bypass-like (DR shifts, no update action).
- **`tev` & `vs_uir`:** latch `ir` ← `ir_in`. If the new value is RDATA and the FSM is IDLE, launch a read at `addr`.
- **`tev` & `vs_cdr`:** load `dr`. RDATA → `rbuf`; STATUS → {0…, overrun, busy, cpu_reset}; otherwise `dr` is unchanged.
- **`tev` & `vs_sdr`:** `dr` ← {tdi, dr[DATA_W-1:1]}. `tdo` follows `dr[0]` (registered).
- **`tev` & `vs_udr`, by `ir`:**
  - CTRL: `cpu_reset` ← dr[0]; dr[1]=1 clears `overrun`.
  - ADDR: `addr` ← dr[ADDR_W-1:0].
  - WDATA: launch write of `dr` at `addr`.
  - RDATA: launch read at `addr`, prefetching the next word.
- **FSM states:** IDLE, WRITE, READ.
  - IDLE→WRITE/READ on launch.
  - WRITE/READ→IDLE on `bus_ack`.
  - On ack: `addr` ← addr + ADDR_INC, modulo 2^ADDR_W, wrapping silently. READ also loads `rbuf` ← `bus_rdata`.
- **Busy launch:** a launch while not IDLE is dropped and sets sticky `overrun`. ADDR or CTRL update while busy is still applied; `bus_addr` stays frozen until ack.
- `busy` = FSM ≠ IDLE.

## Timing
- Requirement: f_clk ≥ 4 × f_tck.
- Reset values: `tdo`, `bus_req`, `bus_we`, `cpu_reset`, `overrun` = 0; `bus_addr`, `bus_wdata`, `addr`, `rbuf`, `dr` = 0; `ir` = 0; FSM IDLE.
- Launch latency: `bus_req` rises on the clk after `tev`.
- Request hold: `bus_req`, `bus_we`, `bus_addr`, `bus_wdata` stay stable until the cycle `bus_ack` is sampled high. `bus_req` drops the next cycle.
- Back-to-back: a new `bus_req` is earliest one clk after ack. `bus_ack` outside a request is ignored.
- Ack in the launch cycle is impossible, since req is registered.
- Launch and ack in the same clk: the ack completes the old transfer, then the launch starts from IDLE next cycle. It is not an overrun.
- Read-back contract: data captured by CDR in RDATA is the word completed by the previous update. The host allows ≥1 idle TCK so the ack lands before capture.
- `reset_n` mid-transfer: `bus_req` drops asynchronously; the transfer is abandoned.

## Structure
- Package `jtag_bridge_pkg`: IR code constants, FSM state enum, STATUS bit positions.
- Sub-module `jtag_sampler`: SYNC_STAGES synchroniser for tck/tdi/state lines plus the `tev` edge detector.
- Top holds DR/IR, CTRL/STATUS, and the bus FSM.

## Test plan
- **Write:** ADDR=0x100, WDATA 0xDEADBEEF, WDATA 0x12345678 → two writes at 0x100 and 0x102 with matching data; `addr`=0x104.
- **Read-back:** preload 0x200=0xA5A5A5A5 and 0x202=0x5A5A5A5A; ADDR=0x200, IR=RDATA; first DR shift returns 0xA5A5A5A5, second returns 0x5A5A5A5A.
- **Overrun:** hold `bus_ack` low for 200 clk; issue two WDATA updates → one request only. STATUS reads overrun=1, busy=1. CTRL dr[1]=1 clears overrun.
- **CTRL:** CTRL dr=1 → `cpu_reset`=1; STATUS bit0=1; CTRL dr=0 → `cpu_reset`=0.
- **Wrap and reset:** ADDR=0xFFFFFFFE, write → next `addr`=0. Assert `reset_n` low with `bus_req` high → `bus_req`=0 immediately and all outputs return to reset values.
- **Clock ratio:** f_clk/f_tck = 4 and 13 with random TCK jitter → bit-exact results in both cases.
